// File: rtl/target_lut_pkg.sv
// Shared types and sizing for the programmable branch-target table and its boot-time loader.
package target_lut_pkg;
    localparam int ENTRIES  = 32;
    localparam int TW       = 10;
    localparam int IW       = $clog2(ENTRIES);
    localparam int MAX_WR   = 32;
    localparam int CW       = 6;
    localparam int END_FLAG = 7;

    typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, WRITE, DONE} lut_ld_state_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [TW-1:0] tgt;
    } lut_entry_t;
endpackage

// File: rtl/lut_byte_parser.sv
// Loader FSM: assembles HI/LO byte pairs into table writes and tracks session count and error.
module lut_byte_parser
    import target_lut_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx,
    output logic [TW-1:0] wr_tgt,
    output logic          load_done,
    output logic          err,
    output logic [CW-1:0] wr_count
);
    lut_ld_state_t state_q, state_d;
    lut_entry_t    ent_q, ent_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        cnt_inc = (cnt_q == CW'(MAX_WR)) ? cnt_q : cnt_q + CW'(1);
        case (state_q)
            GET_HI: if (in_valid) begin
                if (in_data[END_FLAG]) begin
                    state_d = DONE;
                end else begin
                    ent_d.idx           = in_data[2 +: IW];
                    ent_d.tgt[TW-1:8]   = in_data[TW-9:0];
                    state_d             = GET_LO;
                end
            end
            GET_LO: if (in_valid) begin
                ent_d.tgt[7:0] = in_data;
                state_d        = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(MAX_WR)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = GET_HI;
                end
            end
            IDLE, DONE: ;
            default: state_d = IDLE;
        endcase
        // A restart wins over everything, including a write pending this cycle.
        if (start) begin
            state_d = GET_HI;
            cnt_d   = '0;
            err_d   = 1'b0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ent_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Bytes offered together with start are not accepted, so none is silently lost.
    assign in_ready  = ((state_q == GET_HI) || (state_q == GET_LO)) && !start;
    assign wr_idx    = ent_q.idx;
    assign wr_tgt    = ent_q.tgt;
    assign load_done = (state_q == DONE);
    assign err       = err_q;
    assign wr_count  = cnt_q;
endmodule

// File: rtl/target_lut_writer.sv
// Branch-target table filled from a byte stream; fetch reads it combinationally by index.
module target_lut_writer
    import target_lut_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] addr,
    output logic [TW-1:0] Target,
    output logic          load_done,
    output logic          err,
    output logic [CW-1:0] wr_count
);
    logic [ENTRIES-1:0][TW-1:0] table_q, table_d;
    logic [ENTRIES-1:0]         valid_q, valid_d;
    logic                       wr_en;
    logic [IW-1:0]              wr_idx;
    logic [TW-1:0]              wr_tgt;

    lut_byte_parser u_parser (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_tgt    (wr_tgt),
        .load_done (load_done),
        .err       (err),
        .wr_count  (wr_count)
    );

    always_comb begin
        table_d = table_q;
        valid_d = valid_q;
        if (start) begin
            table_d = '0;
            valid_d = '0;
        end else if (wr_en) begin
            table_d[wr_idx] = wr_tgt;
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            table_q <= '0;
            valid_q <= '0;
        end else begin
            table_q <= table_d;
            valid_q <= valid_d;
        end
    end

    // Registered table: a write shows up on Target the cycle after WRITE.
    assign Target = valid_q[addr] ? table_q[addr] : '0;
endmodule

// File: tb/tb_target_lut_writer.sv
// Randomized bench for target_lut_writer against an array-based model of the load session.
module tb_target_lut_writer;
    import target_lut_pkg::*;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] addr = '0;
    logic [TW-1:0] Target;
    logic          load_done;
    logic          err;
    logic [CW-1:0] wr_count;

    target_lut_writer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr      (addr),
        .Target    (Target),
        .load_done (load_done),
        .err       (err),
        .wr_count  (wr_count)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: the table as the fetch stage should see it after the session.
    int exp_tab[ENTRIES];
    int exp_cnt;
    bit exp_err;
    bit exp_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) exp_tab[i] = 0;
        exp_cnt  = 0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (1) begin
            @(negedge Clk);
            if (in_ready) break;
            t++;
            if (t > 20) begin
                chk("handshake_timeout", 0, 1);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_entry(input int idx, input int tgt, input int gap_hi, input int gap_lo);
        logic [7:0] hi, lo;
        logic [9:0] t10;
        logic [4:0] i5;
        t10 = tgt[9:0];
        i5  = idx[4:0];
        hi  = {1'b0, i5, t10[9:8]};
        lo  = t10[7:0];
        send_byte(hi, gap_hi);
        send_byte(lo, gap_lo);
        exp_tab[idx] = tgt;
        if (exp_cnt < MAX_WR) exp_cnt++;
        if (exp_cnt == MAX_WR) begin
            exp_err  = 1'b1;
            exp_done = 1'b1;
        end
    endtask

    task automatic send_end(input int gap);
        logic [6:0] junk;
        junk = 7'($urandom);
        send_byte({1'b1, junk}, gap);
        exp_done = 1'b1;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!load_done && t < 10) begin
            tick();
            t++;
        end
        chk("done_wait", load_done, 1);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < ENTRIES; i++) begin
            addr = IW'(i);
            #1;
            chk({tag, "_tgt"}, Target, exp_tab[i]);
        end
        chk({tag, "_done"}, load_done, exp_done);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_cnt"}, wr_count, exp_cnt);
    endtask

    initial begin
        model_clear();
        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", wr_count, 0);
        chk("rst_tgt", Target, 0);
        Reset_n = 1'b1;
        tick();
        chk("idle_ready", in_ready, 0);

        // Basic load
        do_start();
        send_entry(0, 'h040, 0, 0);
        send_entry(2, 'h30E, 0, 0);
        send_end(0);
        wait_done();
        check_all("basic");

        // Backpressure between HI and LO
        do_start();
        send_entry(9, 'h2A7, 0, 5);
        send_end(2);
        wait_done();
        check_all("bp");

        // Duplicate index: last write wins
        do_start();
        send_entry(5, 'h100, 0, 0);
        send_entry(5, 'h155, 1, 0);
        send_end(0);
        wait_done();
        check_all("dup");

        // Overflow: 32 writes without END
        do_start();
        for (int i = 0; i < MAX_WR; i++)
            send_entry(int'($urandom_range(0, ENTRIES - 1)), int'($urandom_range(0, 1023)), 0, 0);
        wait_done();
        check_all("ovf");
        in_data  = 8'h15;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("ovf_ready", in_ready, 0);
        end
        tick();
        in_valid = 1'b0;
        check_all("ovf_after");

        // Async reset while waiting for LO
        do_start();
        send_byte(8'h0C, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_ready", in_ready, 0);
        chk("arst_done", load_done, 0);
        #1;
        Reset_n = 1'b1;
        model_clear();
        tick();
        check_all("arst");
        chk("arst_idle_ready", in_ready, 0);

        // Same-cycle read of an entry being written
        do_start();
        addr = 5'd7;
        send_byte({1'b0, 5'd7, 2'b01}, 0);
        send_byte(8'h98, 0);
        chk("rd_old", Target, 0);
        tick();
        chk("rd_new", Target, 408);
        exp_tab[7] = 'h198;
        exp_cnt    = 1;
        send_end(0);
        wait_done();
        check_all("rd");
        do_start();
        addr = 5'd7;
        #1;
        chk("restart_tgt7", Target, 0);
        chk("restart_done", load_done, 0);

        // Restart in the middle of an entry discards it and the old table
        send_entry(3, 'h3FF, 0, 0);
        send_byte(8'h11, 0);
        do_start();
        send_entry(4, 'h0AB, 0, 0);
        send_end(0);
        wait_done();
        check_all("midrestart");

        // Random sessions with gaps and clustered indices
        for (int s = 0; s < 6; s++) begin
            int n;
            do_start();
            n = int'($urandom_range(0, 14));
            for (int e = 0; e < n; e++) begin
                int idx;
                idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, ENTRIES - 1));
                send_entry(idx, int'($urandom_range(0, 1023)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
            send_end(int'($urandom_range(0, 2)));
            wait_done();
            check_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
